// File: rtl/regfile_wr_arbiter_if.sv
// Purpose: bundles the two requester write ports, the memory-ready enable,
//          the register-file write port and the status outputs of the
//          register-file write arbiter.
// Signals:
//   enable                        register file ready (retires held write)
//   a_valid/a_ready/a_addr/a_data requester A (ALU writeback)
//   b_valid/b_ready/b_addr/b_data requester B (load unit)
//   rf_write_en/rf_addr_wr/rf_data_wr  register-file write port
//   pending_mask                  one-hot of register held in output stage
//   r0_drop_cnt                   saturating count of discarded R0 writes
// Modports: master = requesters/environment side, slave = arbiter side.
interface regfile_wr_arbiter_if;
  logic       enable;
  logic       a_valid;
  logic       a_ready;
  logic [2:0] a_addr;
  logic [7:0] a_data;
  logic       b_valid;
  logic       b_ready;
  logic [2:0] b_addr;
  logic [7:0] b_data;
  logic       rf_write_en;
  logic [2:0] rf_addr_wr;
  logic [7:0] rf_data_wr;
  logic [7:0] pending_mask;
  logic [3:0] r0_drop_cnt;

  modport master (
    output enable, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rf_write_en, rf_addr_wr, rf_data_wr,
           pending_mask, r0_drop_cnt
  );

  modport slave (
    input  enable, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rf_write_en, rf_addr_wr, rf_data_wr,
           pending_mask, r0_drop_cnt
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Purpose: arbitrates register-file writes from two requesters (A = ALU
//          writeback, B = load unit) into a one-entry output stage that
//          drives the register file. Round-robin on contention; writes to
//          R0 are accepted but discarded and counted.
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  regfile_wr_arbiter_if.slave (requesters, enable, rf port, status)
module regfile_wr_arbiter (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);

  logic       out_valid_q, out_valid_d;
  logic [2:0] out_addr_q,  out_addr_d;
  logic [7:0] out_data_q,  out_data_d;
  logic       prio_q,      prio_d;      // 0: A first, 1: B first
  logic [3:0] drop_cnt_q,  drop_cnt_d;

  logic       stage_free;
  logic       grant_a;
  logic       grant_b;
  logic [2:0] xfer_addr;
  logic [7:0] xfer_data;

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    prio_d      = prio_q;
    drop_cnt_d  = drop_cnt_q;

    // A held write retiring this edge frees the stage for a same-cycle reload.
    stage_free = !out_valid_q | bus.enable;
    // rst gating keeps both readies low while reset is asserted.
    grant_a = !rst & stage_free & bus.a_valid & (!bus.b_valid | !prio_q);
    grant_b = !rst & stage_free & bus.b_valid & (!bus.a_valid |  prio_q);

    xfer_addr = grant_a ? bus.a_addr : bus.b_addr;
    xfer_data = grant_a ? bus.a_data : bus.b_data;

    if (out_valid_q && bus.enable) begin
      out_valid_d = 1'b0;
    end

    if (grant_a || grant_b) begin
      prio_d = grant_a;
      if (xfer_addr != 3'd0) begin
        out_valid_d = 1'b1;
        out_addr_d  = xfer_addr;
        out_data_d  = xfer_data;
      end else if (drop_cnt_q != 4'hF) begin
        drop_cnt_d = drop_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= 3'd0;
      out_data_q  <= 8'h00;
      prio_q      <= 1'b0;
      drop_cnt_q  <= 4'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      prio_q      <= prio_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.a_ready      = grant_a;
  assign bus.b_ready      = grant_b;
  assign bus.rf_write_en  = out_valid_q;
  assign bus.rf_addr_wr   = out_addr_q;
  assign bus.rf_data_wr   = out_data_q;
  assign bus.pending_mask = out_valid_q ? (8'h01 << out_addr_q) : 8'h00;
  assign bus.r0_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.enable  = 1'b0;
    bus.a_valid = 1'b0;
    bus.a_addr  = 3'd0;
    bus.a_data  = 8'h00;
    bus.b_valid = 1'b0;
    bus.b_addr  = 3'd0;
    bus.b_data  = 8'h00;
  endtask

  // Assert reset across two edges; release #1 after an edge.
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable  = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_addr  = 3'd4;
    bus.b_valid = 1'b1;
    bus.b_addr  = 3'd2;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got a=%b b=%b want 0 0", bus.a_ready, bus.b_ready);
    end
    n_cmp++;
    if (bus.rf_write_en !== 1'b0 || bus.pending_mask !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out: got en=%b mask=%h want 0 00", bus.rf_write_en, bus.pending_mask);
    end
    n_cmp++;
    if (bus.r0_drop_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d want 0", bus.r0_drop_cnt);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_single();
    drive_idle();
    do_reset();
    bus.enable  = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_addr  = 3'd3;
    bus.a_data  = 8'h5A;
    @(negedge clk);
    n_cmp++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready: got a=%b b=%b want 1 0", bus.a_ready, bus.b_ready);
    end
    @(posedge clk);
    #1 bus.a_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.rf_write_en !== 1'b1 || bus.rf_addr_wr !== 3'd3 ||
        bus.rf_data_wr !== 8'h5A || bus.pending_mask !== 8'h08) begin
      n_fail++;
      $display("FAIL single_out: got en=%b addr=%0d data=%h mask=%h want 1 3 5a 08",
               bus.rf_write_en, bus.rf_addr_wr, bus.rf_data_wr, bus.pending_mask);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (bus.rf_write_en !== 1'b0 || bus.pending_mask !== 8'h00) begin
      n_fail++;
      $display("FAIL single_retire: got en=%b mask=%h want 0 00", bus.rf_write_en, bus.pending_mask);
    end
  endtask

  task automatic test_contention();
    drive_idle();
    bus.enable  = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_addr  = 3'd1;
    bus.a_data  = 8'hA1;
    bus.b_valid = 1'b1;
    bus.b_addr  = 3'd2;
    bus.b_data  = 8'hB2;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.a_ready !== (i % 2 == 0) || bus.b_ready !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL contention_grant[%0d]: got a=%b b=%b want a=%b b=%b",
                 i, bus.a_ready, bus.b_ready, (i % 2 == 0), (i % 2 == 1));
      end
      if (i > 0) begin
        n_cmp++;
        if (bus.rf_write_en !== 1'b1 || bus.rf_addr_wr !== ((i % 2 == 1) ? 3'd1 : 3'd2)) begin
          n_fail++;
          $display("FAIL contention_addr[%0d]: got en=%b addr=%0d want 1 %0d",
                   i, bus.rf_write_en, bus.rf_addr_wr, (i % 2 == 1) ? 1 : 2);
        end
      end
      @(posedge clk);
      #1;
    end
    drive_idle();
  endtask

  task automatic test_stall();
    drive_idle();
    do_reset();
    bus.enable  = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_addr  = 3'd5;
    bus.a_data  = 8'h77;
    @(posedge clk);
    #1;
    bus.enable  = 1'b0;
    bus.a_addr  = 3'd1;
    bus.a_data  = 8'h11;
    bus.b_valid = 1'b1;
    bus.b_addr  = 3'd2;
    bus.b_data  = 8'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_ready[%0d]: got a=%b b=%b want 0 0", i, bus.a_ready, bus.b_ready);
      end
      n_cmp++;
      if (bus.rf_write_en !== 1'b1 || bus.rf_addr_wr !== 3'd5 || bus.rf_data_wr !== 8'h77) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got en=%b addr=%0d data=%h want 1 5 77",
                 i, bus.rf_write_en, bus.rf_addr_wr, bus.rf_data_wr);
      end
      @(posedge clk);
      #1;
    end
    bus.enable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got a=%b b=%b want 0 1", bus.a_ready, bus.b_ready);
    end
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    n_cmp++;
    if (bus.rf_write_en !== 1'b1 || bus.rf_addr_wr !== 3'd2 || bus.rf_data_wr !== 8'h22) begin
      n_fail++;
      $display("FAIL stall_next: got en=%b addr=%0d data=%h want 1 2 22",
               bus.rf_write_en, bus.rf_addr_wr, bus.rf_data_wr);
    end
  endtask

  task automatic test_r0();
    drive_idle();
    do_reset();
    bus.enable  = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_addr  = 3'd0;
    bus.a_data  = 8'hEE;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.a_ready !== 1'b1 || bus.rf_write_en !== 1'b0 ||
          bus.r0_drop_cnt !== 4'((i > 15) ? 15 : i)) begin
        n_fail++;
        $display("FAIL r0_step[%0d]: got rdy=%b en=%b cnt=%0d want 1 0 %0d",
                 i, bus.a_ready, bus.rf_write_en, bus.r0_drop_cnt, (i > 15) ? 15 : i);
      end
      @(posedge clk);
      #1;
    end
    // 17 A transfers leave B with priority.
    bus.b_valid = 1'b1;
    bus.b_addr  = 3'd0;
    @(negedge clk);
    n_cmp++;
    if (bus.r0_drop_cnt !== 4'd15) begin
      n_fail++;
      $display("FAIL r0_saturate: got %0d want 15", bus.r0_drop_cnt);
    end
    n_cmp++;
    if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL r0_prio: got a=%b b=%b want 0 1", bus.a_ready, bus.b_ready);
    end
    @(posedge clk);
    #1 drive_idle();
  endtask

  task automatic test_reset_midop();
    drive_idle();
    do_reset();
    bus.enable  = 1'b1;
    bus.a_valid = 1'b1;
    bus.a_addr  = 3'd6;
    bus.a_data  = 8'hC3;
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    n_cmp++;
    if (bus.rf_write_en !== 1'b1 || bus.rf_addr_wr !== 3'd6 || bus.pending_mask !== 8'h40) begin
      n_fail++;
      $display("FAIL midop_loaded: got en=%b addr=%0d mask=%h want 1 6 40",
               bus.rf_write_en, bus.rf_addr_wr, bus.pending_mask);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.rf_write_en !== 1'b0 || bus.pending_mask !== 8'h00) begin
      n_fail++;
      $display("FAIL midop_async: got en=%b mask=%h want 0 00", bus.rf_write_en, bus.pending_mask);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rf_write_en !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_after[%0d]: got en=%b addr=%0d want en 0",
                 i, bus.rf_write_en, bus.rf_addr_wr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: a one-slot mailbox feeding the register file. A requester
  // may hand over a write when the mailbox is empty or being emptied this
  // cycle; on a tie, whoever did not win the previous hand-over goes first.
  task automatic test_random();
    bit       m_busy;
    bit [2:0] m_addr;
    bit [7:0] m_data;
    bit       m_last_a;
    int       m_drops;
    int       winner;   // 0 none, 1 A, 2 B
    drive_idle();
    do_reset();
    m_busy   = 0;
    m_addr   = 0;
    m_data   = 0;
    m_last_a = 0;
    m_drops  = 0;
    for (int i = 0; i < 400; i++) begin
      bus.enable  = ($urandom_range(0, 9) < 7);
      bus.a_valid = $urandom_range(0, 1);
      bus.a_addr  = 3'($urandom_range(0, 7));
      bus.a_data  = 8'($urandom);
      bus.b_valid = $urandom_range(0, 1);
      bus.b_addr  = 3'($urandom_range(0, 7));
      bus.b_data  = 8'($urandom);

      winner = 0;
      if (!m_busy || bus.enable) begin
        if (bus.a_valid && bus.b_valid) winner = m_last_a ? 2 : 1;
        else if (bus.a_valid)           winner = 1;
        else if (bus.b_valid)           winner = 2;
      end

      @(negedge clk);
      n_cmp++;
      if (bus.a_ready !== (winner == 1) || bus.b_ready !== (winner == 2)) begin
        n_fail++;
        $display("FAIL rand_grant[%0d]: got a=%b b=%b want a=%b b=%b",
                 i, bus.a_ready, bus.b_ready, (winner == 1), (winner == 2));
      end
      n_cmp++;
      if (bus.rf_write_en !== m_busy ||
          (m_busy && (bus.rf_addr_wr !== m_addr || bus.rf_data_wr !== m_data)) ||
          bus.pending_mask !== (m_busy ? 8'(1 << m_addr) : 8'h00)) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got en=%b addr=%0d data=%h mask=%h want en=%b addr=%0d data=%h",
                 i, bus.rf_write_en, bus.rf_addr_wr, bus.rf_data_wr, bus.pending_mask,
                 m_busy, m_addr, m_data);
      end
      n_cmp++;
      if (bus.r0_drop_cnt !== 4'(m_drops)) begin
        n_fail++;
        $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, bus.r0_drop_cnt, m_drops);
      end

      @(posedge clk);
      if (m_busy && bus.enable) m_busy = 0;
      if (winner != 0) begin
        m_last_a = (winner == 1);
        if ((winner == 1 ? bus.a_addr : bus.b_addr) == 3'd0) begin
          if (m_drops < 15) m_drops++;
        end else begin
          m_busy = 1;
          m_addr = (winner == 1) ? bus.a_addr : bus.b_addr;
          m_data = (winner == 1) ? bus.a_data : bus.b_data;
        end
      end
      #1;
    end
    drive_idle();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive_idle();
    #12 rst = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_r0();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
